// File: rtl/clkdiv_sched.sv
// clkdiv_sched: run-time sequencer for the fabric clock divider. It applies
// divisor changes and stops only on period boundaries, so outclk never runts.
// Ports: clk, rst_n (sync, active-low), run level, cfg_valid/cfg_div/cfg_ready
//   handshake, cfg_err pulse, outclk, tick, busy, state[1:0].
// Option: define CLKDIV_SCHED_PERIOD_CNT_EN to add period_cnt[15:0].
module clkdiv_sched #(
  parameter int W       = 8,
  parameter int DEF_DIV = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         outclk,
  output logic         tick,
  output logic         busy,
  output logic [1:0]   state
`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
  ,
  output logic [15:0]  period_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         pend_q, pend_d;
  logic         outclk_q, outclk_d;
  logic         tick_q, tick_d;
  logic         cfg_err_q, cfg_err_d;

  logic         boundary;
  logic         accept;
  logic         bad_div;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] lo_d;

`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
  logic [15:0]  pcnt_q, pcnt_d;
`endif

  assign cfg_ready = !pend_q;
  assign accept    = cfg_valid && !pend_q;
  assign bad_div   = (cfg_div < W'(2));
  assign boundary  = (state_q != IDLE) &&
                     (cnt_q == div_q - W'(1));
  assign cnt_inc   = boundary ? '0 : cnt_q + W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    cfg_err_d  = accept && bad_div;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (run) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (!run) state_d = boundary ? IDLE : STOP;
      end
      STOP: begin
        cnt_d = cnt_inc;
        if (run)           state_d = RUN;
        else if (boundary) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A pending divisor lands on a boundary, or at once if
    // the last boundary already dropped us into IDLE.
    if (pend_q && (boundary || state_q == IDLE)) begin
      div_d  = pend_div_q;
      pend_d = 1'b0;
    end

    // Only seen when pend_q=0, so never races the apply above.
    if (accept && !bad_div) begin
      if (state_q == IDLE) begin
        div_d = cfg_div;
      end else begin
        pend_d     = 1'b1;
        pend_div_d = cfg_div;
      end
    end

    lo_d     = div_d - (div_d >> 1);
    outclk_d = (state_d != IDLE) && (cnt_d >= lo_d);
    tick_d   = (state_d != IDLE) && (cnt_d == lo_d);
  end

`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
  assign pcnt_d = boundary ? pcnt_q + 16'd1 : pcnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= W'(DEF_DIV);
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      outclk_q   <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
      pcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      outclk_q   <= outclk_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
      pcnt_q     <= pcnt_d;
`endif
    end
  end

  assign outclk  = outclk_q;
  assign tick    = tick_q;
  assign cfg_err = cfg_err_q;
  assign busy    = (state_q != IDLE);
  assign state   = state_q;

`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
  assign period_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_clkdiv_sched.sv
// tb_clkdiv_sched: directed bench for clkdiv_sched.
// Walks reset, default run, live divisor change, bad divisors, stop, reset.
module tb_clkdiv_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       outclk;
  logic       tick;
  logic       busy;
  logic [1:0] state;
`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  int checks = 0;
  int errors = 0;

  clkdiv_sched #(.W(8), .DEF_DIV(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .outclk    (outclk),
    .tick      (tick),
    .busy      (busy),
    .state     (state)
`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered one edge into a period (cnt=0); leaves at cnt=0 of
  // the next. Low for div-div/2 cycles, then high, tick on rise.
  task automatic expect_period(input int div, input string tag);
    int lo;
    lo = div - div / 2;
    for (int c = 0; c < div; c++) begin
      chk({tag, "_clk"}, 32'(outclk), 32'(c >= lo));
      chk({tag, "_tick"}, 32'(tick), 32'(c == lo));
      step(1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    run       = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;

    // T1 reset held with run high
    step(3);
    chk("t1_outclk", 32'(outclk), 0);
    chk("t1_tick", 32'(tick), 0);
    chk("t1_state", 32'(state), 0);
    chk("t1_ready", 32'(cfg_ready), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_err", 32'(cfg_err), 0);
`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
    chk("t1_pcnt", 32'(period_cnt), 0);
`endif

    // T2 default divisor 8: first rise on the 5th edge from here
    rst_n = 1'b1;
    step(1);
    chk("t2_state", 32'(state), 1);
    chk("t2_busy", 32'(busy), 1);
    step(3);
    chk("t2_pre_rise", 32'(outclk), 0);
    step(1);
    chk("t2_rise5", 32'(outclk), 1);
    chk("t2_tick5", 32'(tick), 1);
    step(4);
    expect_period(8, "t2_p8");
    expect_period(8, "t2_p8b");
`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
    chk("t2_pcnt", 32'(period_cnt), 3);
`endif

    // T3 live change to 5 offered at cnt=2
    step(2);
    cfg_valid = 1'b1;
    cfg_div   = 8'd5;
    chk("t3_ready_pre", 32'(cfg_ready), 1);
    step(1);
    cfg_valid = 1'b0;
    chk("t3_ready_hold", 32'(cfg_ready), 0);
    chk("t3_low_cnt3", 32'(outclk), 0);
    step(1);
    chk("t3_still8", 32'(outclk), 1);
    chk("t3_tick8", 32'(tick), 1);
    step(3);
    chk("t3_ready_bnd", 32'(cfg_ready), 0);
    chk("t3_high_bnd", 32'(outclk), 1);
    step(1);
    chk("t3_ready_post", 32'(cfg_ready), 1);
    expect_period(5, "t3_p5");
    expect_period(5, "t3_p5b");

    // T4 divisors 1 and 0 are rejected
    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    step(1);
    chk("t4_err1", 32'(cfg_err), 1);
    chk("t4_ready1", 32'(cfg_ready), 1);
    cfg_div = 8'd0;
    step(1);
    chk("t4_err0", 32'(cfg_err), 1);
    cfg_valid = 1'b0;
    step(1);
    chk("t4_err_clr", 32'(cfg_err), 0);
    step(2);
    expect_period(5, "t4_p5");

    // T5 move to 6, then stop at cnt=2
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    step(1);
    cfg_valid = 1'b0;
    step(4);
    expect_period(6, "t5_p6");
    step(2);
    run = 1'b0;
    step(1);
    chk("t5_stop", 32'(state), 2);
    chk("t5_stop_hi", 32'(outclk), 1);
    chk("t5_stop_tick", 32'(tick), 1);
    step(2);
    chk("t5_stop_bnd", 32'(state), 2);
    step(1);
    chk("t5_idle", 32'(state), 0);
    chk("t5_idle_clk", 32'(outclk), 0);
    chk("t5_idle_busy", 32'(busy), 0);
    step(2);
    chk("t5_idle_hold", 32'(outclk), 0);

    // Re-run, drop run at cnt=1, reassert while in STOP
    run = 1'b1;
    step(2);
    run = 1'b0;
    step(1);
    chk("t5_stop2", 32'(state), 2);
    run = 1'b1;
    step(1);
    chk("t5_rerun", 32'(state), 1);
    chk("t5_rerun_hi", 32'(outclk), 1);
    step(3);
    expect_period(6, "t5_cont");

    // run falls on the RUN boundary: straight to IDLE
    step(5);
    run = 1'b0;
    step(1);
    chk("t5_bnd_idle", 32'(state), 0);
    chk("t5_bnd_clk", 32'(outclk), 0);

    // T6 reset with a divisor pending
    run = 1'b1;
    step(2);
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    step(1);
    cfg_valid = 1'b0;
    chk("t6_pend", 32'(cfg_ready), 0);
    rst_n = 1'b0;
    step(1);
    chk("t6_state", 32'(state), 0);
    chk("t6_ready", 32'(cfg_ready), 1);
    chk("t6_outclk", 32'(outclk), 0);
`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
    chk("t6_pcnt0", 32'(period_cnt), 0);
`endif
    rst_n = 1'b1;
    step(1);
    expect_period(8, "t6_p8");
    expect_period(8, "t6_p8b");
`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
    chk("t6_pcnt2", 32'(period_cnt), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
